// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and select.
// Also flags load-use hazards so ID can hold while a bubble goes down.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [3:0]        id_alu_op,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic              id_use_imm,
  input  logic              id_use_shamt,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_rd_addr,
  input  logic [DATA_W-1:0] exm_result,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_rd_addr,
  input  logic [DATA_W-1:0] mwb_result,
  output logic              ex_valid,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_op_x,
  output logic [DATA_W-1:0] alu_op_y,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              load_use_stall
);

  typedef struct packed {
    logic              valid;
    logic [3:0]        op;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        shamt;
    logic              use_imm;
    logic              use_shamt;
    logic [REG_AW-1:0] rd_addr;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } id_ex_t;

  id_ex_t q;
  id_ex_t d_id;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  always_comb begin
    d_id           = '0;
    d_id.valid     = id_valid;
    d_id.op        = id_alu_op;
    d_id.rs_addr   = id_rs_addr;
    d_id.rt_addr   = id_rt_addr;
    d_id.rs_data   = id_rs_data;
    d_id.rt_data   = id_rt_data;
    d_id.imm       = id_imm;
    d_id.shamt     = id_shamt;
    d_id.use_imm   = id_use_imm;
    d_id.use_shamt = id_use_shamt;
    d_id.rd_addr   = id_rd_addr;
    d_id.reg_write = id_reg_write & id_valid;
    d_id.mem_read  = id_mem_read & id_valid;
    d_id.mem_write = id_mem_write & id_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (flush) begin
      q <= '0;
    end else if (stall) begin
      q <= q;
    end else if (load_use_stall) begin
      q <= '0;
    end else begin
      q <= d_id;
    end
  end

  // EX/MEM is younger than MEM/WB, so it wins on a double match.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    logic [DATA_W-1:0] r;
    r = data;
    unique case (1'b1)
      (addr == '0): r = '0;
      (addr != '0) && exm_reg_write && (exm_rd_addr == addr):
        r = exm_result;
      (addr != '0) && !(exm_reg_write && (exm_rd_addr == addr))
        && mwb_reg_write && (mwb_rd_addr == addr):
        r = mwb_result;
      default: r = data;
    endcase
    return r;
  endfunction

  always_comb begin
    fwd_rs = fwd(q.rs_addr, q.rs_data);
    fwd_rt = fwd(q.rt_addr, q.rt_data);
  end

  always_comb begin
    alu_op_x = fwd_rs;
    alu_op_y = fwd_rt;
    unique case (1'b1)
      q.use_shamt: begin
        alu_op_x = fwd_rt;
        alu_op_y = {{(DATA_W-5){1'b0}}, q.shamt};
      end
      !q.use_shamt && q.use_imm: begin
        alu_op_x = fwd_rs;
        alu_op_y = q.imm;
      end
      default: begin
        alu_op_x = fwd_rs;
        alu_op_y = fwd_rt;
      end
    endcase
  end

  always_comb begin
    ex_valid      = q.valid;
    alu_op        = q.op;
    ex_rd_addr    = q.rd_addr;
    ex_reg_write  = q.reg_write;
    ex_mem_read   = q.mem_read;
    ex_mem_write  = q.mem_write;
    ex_store_data = fwd_rt;
  end

  // Both sources compared even if the ID op ignores one of them.
  always_comb begin
    load_use_stall = q.valid && q.mem_read
      && (q.rd_addr != '0) && id_valid
      && ((q.rd_addr == id_rs_addr)
        || (q.rd_addr == id_rt_addr));
  end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomized bench for id_ex_operand_stage against a rule-level model.
// Directed sequences pin the model with literal expectations.
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall, flush;
  logic        id_valid;
  logic [3:0]  id_alu_op;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_use_imm, id_use_shamt;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        exm_reg_write, mwb_reg_write;
  logic [4:0]  exm_rd_addr, mwb_rd_addr;
  logic [31:0] exm_result, mwb_result;

  logic        ex_valid;
  logic [3:0]  alu_op;
  logic [31:0] alu_op_x, alu_op_y, ex_store_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        load_use_stall;

  int n_cmp = 0;
  int n_bad = 0;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_shamt(id_shamt),
    .id_use_imm(id_use_imm), .id_use_shamt(id_use_shamt),
    .id_rd_addr(id_rd_addr), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr),
    .exm_result(exm_result), .mwb_reg_write(mwb_reg_write),
    .mwb_rd_addr(mwb_rd_addr), .mwb_result(mwb_result),
    .ex_valid(ex_valid), .alu_op(alu_op),
    .alu_op_x(alu_op_x), .alu_op_y(alu_op_y),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data),
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  // Model: the instruction currently sitting in EX.
  typedef struct {
    bit       v;
    bit [3:0] op;
    bit [4:0] rs, rt, rd, sh;
    bit [31:0] rsd, rtd, imm;
    bit       ui, us, rw, mr, mw;
  } ins_t;

  ins_t m;

  function automatic ins_t bubble();
    ins_t b;
    b = '{default: 0};
    return b;
  endfunction

  function automatic bit [31:0] fwd(bit [4:0] a, bit [31:0] d);
    if (a == 0) return 0;
    if (exm_reg_write && exm_rd_addr == a) return exm_result;
    if (mwb_reg_write && mwb_rd_addr == a) return mwb_result;
    return d;
  endfunction

  function automatic bit exp_lus();
    return m.v && m.mr && m.rd != 0 && id_valid
      && (m.rd == id_rs_addr || m.rd == id_rt_addr);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic check();
    bit [31:0] rs_v, rt_v, ex_x, ex_y;
    @(negedge clk);
    #1;
    if (!rst_n) m = bubble();
    rs_v = fwd(m.rs, m.rsd);
    rt_v = fwd(m.rt, m.rtd);
    if (m.us) begin
      ex_x = rt_v; ex_y = {27'b0, m.sh};
    end else if (m.ui) begin
      ex_x = rs_v; ex_y = m.imm;
    end else begin
      ex_x = rs_v; ex_y = rt_v;
    end
    chk("ex_valid", ex_valid, m.v);
    chk("alu_op", alu_op, m.op);
    chk("alu_op_x", alu_op_x, ex_x);
    chk("alu_op_y", alu_op_y, ex_y);
    chk("ex_rd_addr", ex_rd_addr, m.rd);
    chk("ex_reg_write", ex_reg_write, m.rw);
    chk("ex_mem_read", ex_mem_read, m.mr);
    chk("ex_mem_write", ex_mem_write, m.mw);
    chk("ex_store_data", ex_store_data, rt_v);
    chk("load_use_stall", load_use_stall, exp_lus());
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n || flush) m = bubble();
    else if (stall) m = m;
    else if (exp_lus()) m = bubble();
    else begin
      m.v = id_valid; m.op = id_alu_op;
      m.rs = id_rs_addr; m.rt = id_rt_addr;
      m.rsd = id_rs_data; m.rtd = id_rt_data;
      m.imm = id_imm; m.sh = id_shamt;
      m.ui = id_use_imm; m.us = id_use_shamt;
      m.rd = id_rd_addr;
      m.rw = id_reg_write && id_valid;
      m.mr = id_mem_read && id_valid;
      m.mw = id_mem_write && id_valid;
    end
    #1;
  endtask

  task automatic clear_in();
    stall = 0; flush = 0; id_valid = 0; id_alu_op = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
    id_use_imm = 0; id_use_shamt = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    exm_reg_write = 0; exm_rd_addr = 0; exm_result = 0;
    mwb_reg_write = 0; mwb_rd_addr = 0; mwb_result = 0;
  endtask

  task automatic rand_in(bit ctl);
    stall = ctl && ($urandom_range(0, 7) == 0);
    flush = ctl && ($urandom_range(0, 15) == 0);
    id_valid = ($urandom_range(0, 3) != 0);
    id_alu_op = 4'($urandom);
    id_rs_addr = 5'($urandom_range(0, 7));
    id_rt_addr = 5'($urandom_range(0, 7));
    id_rd_addr = 5'($urandom_range(0, 7));
    id_rs_data = $urandom; id_rt_data = $urandom;
    id_imm = $urandom; id_shamt = 5'($urandom);
    id_use_imm = 1'($urandom); id_use_shamt = 1'($urandom);
    id_reg_write = 1'($urandom);
    id_mem_read = ($urandom_range(0, 2) == 0);
    id_mem_write = 1'($urandom);
    exm_reg_write = 1'($urandom);
    exm_rd_addr = 5'($urandom_range(0, 7));
    exm_result = $urandom;
    mwb_reg_write = 1'($urandom);
    mwb_rd_addr = 5'($urandom_range(0, 7));
    mwb_result = $urandom;
  endtask

  task automatic step();
    check();
    tick();
  endtask

  initial begin
    m = bubble();
    rst_n = 0;
    rand_in(1'b1);
    check();
    chk("rst ex_valid", ex_valid, 0);
    chk("rst alu_op_x", alu_op_x, 0);
    chk("rst alu_op_y", alu_op_y, 0);
    chk("rst lus", load_use_stall, 0);
    tick();

    rst_n = 1; clear_in();
    id_valid = 1; id_alu_op = 13;
    id_rs_addr = 1; id_rs_data = 32'h5;
    id_rt_addr = 2; id_rt_data = 32'h7;
    step();
    clear_in();
    check();
    chk("cap alu_op", alu_op, 13);
    chk("cap x", alu_op_x, 32'h5);
    chk("cap y", alu_op_y, 32'h7);
    chk("cap valid", ex_valid, 1);
    tick();

    clear_in();
    id_valid = 1; id_rs_addr = 3; id_rs_data = 32'h1111;
    step();
    clear_in(); stall = 1;
    exm_reg_write = 1; exm_rd_addr = 3; exm_result = 32'hAAAA;
    mwb_reg_write = 1; mwb_rd_addr = 3; mwb_result = 32'hBBBB;
    check(); chk("fwd exm", alu_op_x, 32'hAAAA); tick();
    exm_reg_write = 0;
    check(); chk("fwd mwb", alu_op_x, 32'hBBBB); tick();
    clear_in();
    id_valid = 1; id_rs_addr = 0; id_rs_data = 32'h1234;
    step();
    clear_in();
    exm_reg_write = 1; exm_rd_addr = 0; exm_result = 32'hAAAA;
    mwb_reg_write = 1; mwb_rd_addr = 0; mwb_result = 32'hBBBB;
    check(); chk("fwd r0", alu_op_x, 0); tick();

    clear_in();
    id_valid = 1; id_use_imm = 1; id_imm = 32'hFFFF_FFF0;
    id_rs_addr = 1; id_rs_data = 9;
    step();
    clear_in();
    check(); chk("imm y", alu_op_y, 32'hFFFF_FFF0);
    chk("imm x", alu_op_x, 9); tick();
    for (int b = 0; b < 2; b++) begin
      clear_in();
      id_valid = 1; id_use_shamt = 1; id_shamt = 4;
      id_use_imm = 1'(b); id_imm = 32'h55;
      id_rt_addr = 2; id_rt_data = 32'h80;
      step();
      clear_in();
      check(); chk("sh x", alu_op_x, 32'h80);
      chk("sh y", alu_op_y, 4); tick();
    end

    clear_in();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd_addr = 4;
    step();
    clear_in();
    id_valid = 1; id_rt_addr = 4; id_rd_addr = 6;
    id_reg_write = 1; id_alu_op = 2;
    check(); chk("lu stall", load_use_stall, 1); tick();
    check();
    chk("lu bub valid", ex_valid, 0);
    chk("lu bub rw", ex_reg_write, 0);
    chk("lu bub mr", ex_mem_read, 0);
    chk("lu bub rd", ex_rd_addr, 0);
    chk("lu released", load_use_stall, 0);
    tick();
    clear_in();
    check(); chk("lu cap valid", ex_valid, 1);
    chk("lu cap rd", ex_rd_addr, 6); tick();
    id_valid = 1; id_mem_read = 1; id_rd_addr = 0;
    step();
    clear_in(); id_valid = 1; id_rt_addr = 0;
    check(); chk("lu r0", load_use_stall, 0); tick();

    clear_in();
    id_valid = 1; id_alu_op = 5; id_rd_addr = 7;
    id_rs_addr = 1; id_rs_data = 32'h10;
    id_rt_addr = 2; id_rt_data = 32'h20;
    step();
    for (int k = 0; k < 3; k++) begin
      rand_in(1'b0);
      stall = 1; exm_reg_write = 0; mwb_reg_write = 0;
      check();
      chk("stall op", alu_op, 5);
      chk("stall x", alu_op_x, 32'h10);
      chk("stall y", alu_op_y, 32'h20);
      chk("stall rd", ex_rd_addr, 7);
      tick();
    end
    clear_in(); stall = 1; flush = 1;
    step();
    clear_in();
    check(); chk("flush+stall", ex_valid, 0); tick();

    id_valid = 1; id_mem_read = 1; id_rd_addr = 5;
    step();
    clear_in();
    id_valid = 1; id_rs_addr = 5; id_rd_addr = 9; flush = 1;
    check(); chk("fl lu", load_use_stall, 1); tick();
    flush = 0;
    check(); chk("fl bub", ex_valid, 0);
    chk("fl no lu", load_use_stall, 0); tick();
    clear_in();
    check(); chk("fl cap", ex_valid, 1);
    chk("fl cap rd", ex_rd_addr, 9); tick();

    for (int i = 0; i < 3000; i++) begin
      rand_in(1'b1);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage directly upstream of the ALU.
- Captures decoded instruction fields from ID and applies EX/MEM and MEM/WB forwarding to the register operands.
- Selects ALU X/Y operands (register, immediate or shift amount) and drives ALU op/operands plus the EX-stage control bits.
- Detects load-use hazards and inserts a bubble.

Parameters:
- DATA_W, 32, datapath width; fixed at 32, never overridden.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  global freeze; all stage registers hold
- flush  in  1  squash; next stage contents become a bubble
- id_valid  in  1  ID holds a real instruction
- id_alu_op  in  4  ALU op select, same 4-bit encoding the ALU decodes (0 = addu … 14 = sub)
- id_rs_addr, id_rt_addr  in  5  source register numbers
- id_rs_data, id_rt_data  in  32  register-file read data
- id_imm  in  32  already sign/zero-extended immediate
- id_shamt  in  5  shift amount field
- id_use_imm  in  1  Y operand = immediate
- id_use_shamt  in  1  X = rt value, Y = {27'b0, shamt}
- id_rd_addr  in  5  destination register
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- exm_reg_write  in  1  EX/MEM writes a register
- exm_rd_addr  in  5  EX/MEM destination
- exm_result  in  32  EX/MEM value
- mwb_reg_write  in  1  MEM/WB writes a register
- mwb_rd_addr  in  5  MEM/WB destination
- mwb_result  in  32  MEM/WB value
- ex_valid  out  1  EX holds a real instruction
- alu_op  out  4  to ALU op select
- alu_op_x, alu_op_y  out  32  to ALU operands
- ex_rd_addr  out  5  destination
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  control, forced 0 when bubble
- ex_store_data  out  32  forwarded rt value, for stores
- load_use_stall  out  1  ID must hold this cycle

Behaviour:
- Registered state: valid, alu_op, rs/rt addr, rs/rt data, imm, shamt, use_imm, use_shamt, rd_addr, reg_write, mem_read, mem_write.
- Reset (async, rst_n=0): all registers 0. Outputs therefore: ex_valid=0, alu_op=0, alu_op_x=0, alu_op_y=0, ex_rd_addr=0, ex_reg_write=0, ex_mem_read=0, ex_mem_write=0, ex_store_data=0, load_use_stall=0.
- Clock-edge update priority (highest first):
  - flush → bubble.
  - stall → hold all registers.
  - load_use_stall → bubble.
  - Otherwise capture ID fields, with valid=id_valid.
- Bubble: valid=0, reg_write/mem_read/mem_write=0, rd_addr=0, alu_op=0; other fields don't-care but loaded 0.
- id_valid=0 captured normally also forces reg_write/mem_read/mem_write=0.
- Forwarding is combinational in EX, per source (rs, rt):
  - If addr==0 → use 0.
  - Else if exm_reg_write && exm_rd_addr==addr → exm_result.
  - Else if mwb_reg_write && mwb_rd_addr==addr → mwb_result.
  - Else the registered data.
  - EX/MEM beats MEM/WB when both match.
- Operand select:
  - use_shamt=1 → X=fwd_rt, Y={27'b0,shamt}. use_shamt wins over use_imm.
  - use_imm=1 → X=fwd_rs, Y=imm.
  - Else → X=fwd_rs, Y=fwd_rt.
- ex_store_data = fwd_rt always.
- load_use_stall is combinational and equals 1 only when all of: ex_valid, ex_mem_read, ex_rd_addr!=0, id_valid, and (ex_rd_addr==id_rs_addr or ex_rd_addr==id_rt_addr). Both sources are compared conservatively. It is still driven while stall=1, but has no effect on the registers then.
- Latency: ID fields appear on the outputs 1 cycle after capture. Forwarded values pass through combinationally in the same cycle.
- stall freezes the whole pipe, so forwarding sources are stable while held.
- Reset mid-stall or mid-flush: reset wins immediately, asynchronously.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs → all outputs 0; release, then capture id_alu_op=13, rs=$1(0x5), rt=$2(0x7) → next cycle alu_op=13, X=5, Y=7, ex_valid=1.
- Forward priority: EX holds rs=$3; exm writes $3=0xAAAA and mwb writes $3=0xBBBB → alu_op_x=0xAAAA; drop exm_reg_write → 0xBBBB; rs=$0 with both writing $0 → X=0.
- Operand select: use_imm=1, imm=0xFFFFFFF0 → Y=0xFFFFFFF0; use_shamt=1, shamt=4, rt data 0x80 → X=0x80, Y=4; both set → shamt path.
- Load-use: EX is lw to $4 (mem_read=1); ID has rt=$4 → load_use_stall=1, next cycle ex_valid=0 with all controls 0; ID instruction then captured the following cycle. Repeat with ex_rd=$0 → no stall.
- Stall/flush: stall=1 for 3 cycles → outputs constant; flush=1 with stall=1 → bubble next cycle; flush while load-use active → bubble, no double insertion.
